// File: rtl/hart_scheduler.sv
// -----------------------------------------------------------------------------
// hart_scheduler
//
// Barrel-style issue scheduler for a multi-hart pipeline. Keeps one PC per
// hart and issues one hart per cycle, round-robin among eligible harts. An
// issued hart is locked out for LOCKOUT cycles so that its branch can resolve
// in EX before it is fetched again. Harts park on an empty-mailbox read and
// resume on a mailbox post, replaying the read PC.
//
// Ports
//   clk             in   1       clock
//   Reset           in   1       synchronous, active-high reset
//   hart_enable     in   NHARTS  per-hart run enable
//   stall           in   1       freezes selection, issue outputs and lockouts
//   redirect_valid  in   1       taken branch/jump resolved in EX
//   redirect_hart   in   HW      hart of the redirect
//   redirect_pc     in   32      new PC for redirect_hart
//   wait_valid      in   1       EX mailbox read found the mailbox empty
//   wait_hart       in   HW      hart that must park
//   wait_pc         in   32      PC of the mailbox read (replayed on wake)
//   post_valid      in   1       mailbox write targeting a hart
//   post_hart       in   HW      hart being woken
//   issue_valid     out  1       issue_hart/issue_pc valid this cycle
//   issue_hart      out  HW      selected hart ID
//   issue_pc        out  32      PC to fetch for issue_hart
//
// Per-hart states
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_OFF   | hart disabled, never selected
//   S_READY | eligible for selection
//   S_LOCK  | issued recently, waiting for its branch to resolve in EX
//   S_WAIT  | parked on an empty mailbox, waiting for a post
// -----------------------------------------------------------------------------
module hart_scheduler #(
   parameter int          NHARTS   = 4,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          LOCKOUT  = 3,
   localparam int         HW       = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [NHARTS-1:0] hart_enable,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [HW-1:0]     redirect_hart,
   input  logic [31:0]       redirect_pc,
   input  logic              wait_valid,
   input  logic [HW-1:0]     wait_hart,
   input  logic [31:0]       wait_pc,
   input  logic              post_valid,
   input  logic [HW-1:0]     post_hart,
   output logic              issue_valid,
   output logic [HW-1:0]     issue_hart,
   output logic [31:0]       issue_pc
);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_READY = 2'd1,
      S_LOCK  = 2'd2,
      S_WAIT  = 2'd3
   } hart_st_e;

   hart_st_e          st_q   [NHARTS];
   hart_st_e          st_d   [NHARTS];
   logic [2:0]        cnt_q  [NHARTS];
   logic [2:0]        cnt_d  [NHARTS];
   logic [31:0]       pc_q   [NHARTS];
   logic [31:0]       pc_d   [NHARTS];
   logic [NHARTS-1:0] pend_q, pend_d;
   logic [HW-1:0]     rr_q, rr_d;

   logic              issue_valid_q, issue_valid_d;
   logic [HW-1:0]     issue_hart_q, issue_hart_d;
   logic [31:0]       issue_pc_q, issue_pc_d;

   logic [NHARTS-1:0] wait_hit, post_hit, redir_hit, issue_hit, elig;
   logic              sel_valid;
   logic [HW-1:0]     sel_hart;
   logic              do_issue;

   // Per-hart event decode and eligibility. A hart that is being parked or
   // redirected this cycle must not be issued with its stale PC.
   always_comb begin
      wait_hit  = '0;
      post_hit  = '0;
      redir_hit = '0;
      elig      = '0;
      for (int h = 0; h < NHARTS; h++) begin
         wait_hit[h]  = wait_valid     && (wait_hart     == HW'(h));
         post_hit[h]  = post_valid     && (post_hart     == HW'(h));
         redir_hit[h] = redirect_valid && (redirect_hart == HW'(h));
         elig[h]      = (st_q[h] == S_READY) && hart_enable[h]
                        && !wait_hit[h] && !redir_hit[h];
      end
   end

   // Round-robin pick: first eligible hart after the last one issued.
   always_comb begin
      logic [HW-1:0] idx;
      idx       = '0;
      sel_valid = 1'b0;
      sel_hart  = '0;
      for (int i = 1; i <= NHARTS; i++) begin
         idx = HW'((int'(rr_q) + i) % NHARTS);
         if (!sel_valid && elig[idx]) begin
            sel_valid = 1'b1;
            sel_hart  = idx;
         end
      end
   end

   assign do_issue = sel_valid && !stall;

   always_comb begin
      issue_hit = '0;
      for (int h = 0; h < NHARTS; h++) begin
         issue_hit[h] = do_issue && (sel_hart == HW'(h));
      end
   end

   // Per-hart next state. Priority: disable > wait > redirect > issue.
   always_comb begin
      pend_d = pend_q;
      for (int h = 0; h < NHARTS; h++) begin
         st_d[h]  = st_q[h];
         cnt_d[h] = cnt_q[h];
         pc_d[h]  = pc_q[h];

         if (!hart_enable[h]) begin
            st_d[h]   = S_OFF;
            cnt_d[h]  = '0;
            pend_d[h] = 1'b0;
         end else if (st_q[h] == S_OFF) begin
            // Posts, waits and redirects aimed at an OFF hart are dropped.
            st_d[h] = S_READY;
         end else begin
            // The counter is loaded with LOCKOUT-1 at issue; the hart becomes
            // READY on the edge that would take it to zero, so the issue
            // period for a lone hart is exactly LOCKOUT cycles.
            if ((st_q[h] == S_LOCK) && !stall) begin
               if (cnt_q[h] <= 3'd1) begin
                  st_d[h]  = S_READY;
                  cnt_d[h] = '0;
               end else begin
                  cnt_d[h] = cnt_q[h] - 3'd1;
               end
            end

            if (post_hit[h]) begin
               if (st_q[h] == S_WAIT) begin
                  st_d[h] = S_READY;
               end else begin
                  // Remember the wakeup so a later wait does not park.
                  pend_d[h] = 1'b1;
               end
            end

            if (wait_hit[h]) begin
               pc_d[h]  = wait_pc;
               cnt_d[h] = '0;
               if (pend_q[h] || post_hit[h]) begin
                  st_d[h]   = S_READY;
                  pend_d[h] = 1'b0;
               end else begin
                  st_d[h] = S_WAIT;
               end
            end else if (redir_hit[h]) begin
               pc_d[h] = redirect_pc;
            end else if (issue_hit[h]) begin
               pc_d[h] = pc_q[h] + 32'd4;
               if (LOCKOUT > 1) begin
                  st_d[h]  = S_LOCK;
                  cnt_d[h] = 3'(LOCKOUT - 1);
               end else begin
                  st_d[h] = S_READY;
               end
            end
         end
      end
   end

   // Issue outputs: hart and PC hold when nothing is eligible, so fetch can
   // see the last issue for debug; everything holds under stall.
   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_hart_d  = issue_hart_q;
      issue_pc_d    = issue_pc_q;
      rr_d          = rr_q;
      if (!stall) begin
         if (sel_valid) begin
            issue_valid_d = 1'b1;
            issue_hart_d  = sel_hart;
            issue_pc_d    = pc_q[sel_hart];
            rr_d          = sel_hart;
         end else begin
            issue_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int h = 0; h < NHARTS; h++) begin
            st_q[h]  <= S_OFF;
            cnt_q[h] <= '0;
            pc_q[h]  <= RESET_PC;
         end
         pend_q        <= '0;
         rr_q          <= HW'(NHARTS - 1);
         issue_valid_q <= 1'b0;
         issue_hart_q  <= '0;
         issue_pc_q    <= '0;
      end else begin
         for (int h = 0; h < NHARTS; h++) begin
            st_q[h]  <= st_d[h];
            cnt_q[h] <= cnt_d[h];
            pc_q[h]  <= pc_d[h];
         end
         pend_q        <= pend_d;
         rr_q          <= rr_d;
         issue_valid_q <= issue_valid_d;
         issue_hart_q  <= issue_hart_d;
         issue_pc_q    <= issue_pc_d;
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_hart  = issue_hart_q;
   assign issue_pc    = issue_pc_q;

endmodule

// File: tb/tb_hart_scheduler.sv
module tb_hart_scheduler;

   logic        clk = 1'b0;
   logic        Reset;
   logic [3:0]  hart_enable;
   logic        stall;
   logic        redirect_valid;
   logic [1:0]  redirect_hart;
   logic [31:0] redirect_pc;
   logic        wait_valid;
   logic [1:0]  wait_hart;
   logic [31:0] wait_pc;
   logic        post_valid;
   logic [1:0]  post_hart;
   logic        issue_valid;
   logic [1:0]  issue_hart;
   logic [31:0] issue_pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hart_scheduler #(.NHARTS(4), .RESET_PC(32'h0), .LOCKOUT(3)) dut (
      .clk            (clk),
      .Reset          (Reset),
      .hart_enable    (hart_enable),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_hart  (redirect_hart),
      .redirect_pc    (redirect_pc),
      .wait_valid     (wait_valid),
      .wait_hart      (wait_hart),
      .wait_pc        (wait_pc),
      .post_valid     (post_valid),
      .post_hart      (post_hart),
      .issue_valid    (issue_valid),
      .issue_hart     (issue_hart),
      .issue_pc       (issue_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance one edge, then check the issue outputs. Hart/PC only matter
   // when valid is expected.
   task automatic iss(input string tag, input logic v, input int h, input logic [31:0] pc);
      step();
      chk({tag, ".valid"}, 32'(issue_valid), 32'(v));
      if (v) begin
         chk({tag, ".hart"}, 32'(issue_hart), 32'(h));
         chk({tag, ".pc"}, issue_pc, pc);
      end
   endtask

   initial begin
      Reset          = 1'b1;
      hart_enable    = 4'b0000;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_hart  = 2'd0;
      redirect_pc    = 32'h0;
      wait_valid     = 1'b0;
      wait_hart      = 2'd0;
      wait_pc        = 32'h0;
      post_valid     = 1'b0;
      post_hart      = 2'd0;

      step();
      step();
      chk("rst.valid", 32'(issue_valid), 32'd0);
      chk("rst.hart", 32'(issue_hart), 32'd0);
      chk("rst.pc", issue_pc, 32'h0);

      // All harts enabled: plain rotation, PCs advance by 4 per visit.
      Reset       = 1'b0;
      hart_enable = 4'b1111;
      iss("t1_e0", 1'b0, 0, 32'h0);
      iss("t1_e1", 1'b1, 0, 32'h0);
      iss("t1_e2", 1'b1, 1, 32'h0);
      iss("t1_e3", 1'b1, 2, 32'h0);
      iss("t1_e4", 1'b1, 3, 32'h0);
      iss("t1_e5", 1'b1, 0, 32'h4);
      iss("t1_e6", 1'b1, 1, 32'h4);
      iss("t1_e7", 1'b1, 2, 32'h4);
      iss("t1_e8", 1'b1, 3, 32'h4);
      iss("t1_e9", 1'b1, 0, 32'h8);
      iss("t1_e10", 1'b1, 1, 32'h8);
      iss("t1_e11", 1'b1, 2, 32'h8);

      // Redirect hart2 while it is locked out.
      redirect_valid = 1'b1;
      redirect_hart  = 2'd2;
      redirect_pc    = 32'h100;
      iss("t3_e12", 1'b1, 3, 32'h8);
      redirect_valid = 1'b0;
      iss("t3_e13", 1'b1, 0, 32'hC);
      iss("t3_e14", 1'b1, 1, 32'hC);
      iss("t3_e15", 1'b1, 2, 32'h100);
      iss("t3_e16", 1'b1, 3, 32'hC);
      iss("t3_e17", 1'b1, 0, 32'h10);
      iss("t3_e18", 1'b1, 1, 32'h10);
      iss("t3_e19", 1'b1, 2, 32'h104);

      // Park hart1 at 0x40; it is skipped until posted.
      wait_valid = 1'b1;
      wait_hart  = 2'd1;
      wait_pc    = 32'h40;
      iss("t4_e20", 1'b1, 3, 32'h10);
      wait_valid = 1'b0;
      iss("t4_e21", 1'b1, 0, 32'h14);
      iss("t4_e22", 1'b1, 2, 32'h108);
      iss("t4_e23", 1'b1, 3, 32'h14);
      iss("t4_e24", 1'b1, 0, 32'h18);
      iss("t4_e25", 1'b1, 2, 32'h10C);
      post_valid = 1'b1;
      post_hart  = 2'd1;
      iss("t4_e26", 1'b1, 3, 32'h18);
      post_valid = 1'b0;
      iss("t4_e27", 1'b1, 0, 32'h1C);
      iss("t4_e28", 1'b1, 1, 32'h40);
      iss("t4_e29", 1'b1, 2, 32'h110);
      iss("t4_e30", 1'b1, 3, 32'h1C);
      iss("t4_e31", 1'b1, 0, 32'h20);
      iss("t4_e32", 1'b1, 1, 32'h44);

      // Post hart3 early, wait later: the pending wakeup keeps it running.
      post_valid = 1'b1;
      post_hart  = 2'd3;
      iss("t5_e33", 1'b1, 2, 32'h114);
      post_valid = 1'b0;
      iss("t5_e34", 1'b1, 3, 32'h20);
      iss("t5_e35", 1'b1, 0, 32'h24);
      wait_valid = 1'b1;
      wait_hart  = 2'd3;
      wait_pc    = 32'h80;
      iss("t5_e36", 1'b1, 1, 32'h48);
      wait_valid = 1'b0;
      iss("t5_e37", 1'b1, 2, 32'h118);
      iss("t5_e38", 1'b1, 3, 32'h80);
      iss("t5_e39", 1'b1, 0, 32'h28);
      iss("t5_e40", 1'b1, 1, 32'h4C);
      iss("t5_e41", 1'b1, 2, 32'h11C);
      iss("t5_e42", 1'b1, 3, 32'h84);

      // Same-cycle wait and post for hart0: no park, PC replaced.
      wait_valid = 1'b1;
      wait_hart  = 2'd0;
      wait_pc    = 32'h200;
      post_valid = 1'b1;
      post_hart  = 2'd0;
      iss("t5_e43", 1'b1, 1, 32'h50);
      wait_valid = 1'b0;
      post_valid = 1'b0;
      iss("t5_e44", 1'b1, 2, 32'h120);
      iss("t5_e45", 1'b1, 3, 32'h88);
      iss("t5_e46", 1'b1, 0, 32'h200);
      iss("t6_e47", 1'b1, 1, 32'h54);

      // Stall five edges: outputs hold, order resumes unchanged.
      stall = 1'b1;
      iss("t6_s1", 1'b1, 1, 32'h54);
      step();
      iss("t6_s3", 1'b1, 1, 32'h54);
      step();
      iss("t6_s5", 1'b1, 1, 32'h54);
      stall = 1'b0;
      iss("t6_e53", 1'b1, 2, 32'h124);
      iss("t6_e54", 1'b1, 3, 32'h8C);
      iss("t6_e55", 1'b1, 0, 32'h204);
      iss("t6_e56", 1'b1, 1, 32'h58);

      // Reset mid-run with an in-flight post, then a single enabled hart.
      Reset       = 1'b1;
      hart_enable = 4'b0001;
      post_valid  = 1'b1;
      post_hart   = 2'd0;
      step();
      chk("t6_rst.valid", 32'(issue_valid), 32'd0);
      chk("t6_rst.hart", 32'(issue_hart), 32'd0);
      chk("t6_rst.pc", issue_pc, 32'h0);
      Reset      = 1'b0;
      post_valid = 1'b0;
      iss("t2_r1", 1'b0, 0, 32'h0);
      iss("t2_r2", 1'b1, 0, 32'h0);
      iss("t2_r3", 1'b0, 0, 32'h0);
      iss("t2_r4", 1'b0, 0, 32'h0);
      iss("t2_r5", 1'b1, 0, 32'h4);
      iss("t2_r6", 1'b0, 0, 32'h0);
      iss("t2_r7", 1'b0, 0, 32'h0);
      iss("t2_r8", 1'b1, 0, 32'h8);
      chk("t2_r8.hold_hart", 32'(issue_hart), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
